// File: rtl/gru_dh_dw_update_pkg.sv
// ---------------------------------------------------------------------------
// gru_fx_pkg
// Shared fixed-point definitions for the GRU backprop stages: default word
// and fraction widths, the unity constant, clamp limits, a saturating
// narrowing helper and the state encoding of the dh/dW update sequencer.
// No ports (package).
// ---------------------------------------------------------------------------
package gru_fx_pkg;

    localparam int DATABIT = 16;
    localparam int FRAC    = 12;

    localparam logic signed [DATABIT-1:0] ONE  = 16'sh1000;
    localparam logic signed [DATABIT-1:0] MAXV = 16'sh7FFF;
    localparam logic signed [DATABIT-1:0] MINV = 16'sh8000;

    // Sequencer states: one arithmetic step per state, DONE waits on out_ready.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_M1   = 3'd2,
        ST_M2   = 3'd3,
        ST_M3   = 3'd4,
        ST_ADD  = 3'd5,
        ST_DONE = 3'd6
    } gru_state_e;

    // Narrow a one-bit-wider sum/difference back to DATABIT with clamping.
    // Overflow shows up as the two top bits disagreeing.
    function automatic logic signed [DATABIT-1:0] sat(input logic signed [DATABIT:0] v);
        if (v[DATABIT] != v[DATABIT-1])
            sat = v[DATABIT] ? MINV : MAXV;
        else
            sat = v[DATABIT-1:0];
    endfunction

endpackage

// File: rtl/gru_dh_dw_update_if.sv
// ---------------------------------------------------------------------------
// gru_dh_dw_update_if
// Bundle of the request/response signals of the dh/dW update stage.
//   Request : in_valid, in_ready, acc_mode, n, xt, htb, ht1, zt, f3
//   Response: out_valid, out_ready, result, sat_flag
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a producer holds valid (and its data) until that edge and never
// makes valid depend on ready.
// Modports: master = upstream/downstream side, slave = the update block.
// ---------------------------------------------------------------------------
interface gru_dh_dw_update_if #(
    parameter int DATABIT = 16,
    parameter int HNUM    = 4
);
    localparam int NW = $clog2(HNUM);

    logic                      in_valid;
    logic                      in_ready;
    logic                      acc_mode;
    logic [NW-1:0]             n;
    logic [DATABIT-1:0]        xt;
    logic [HNUM*DATABIT-1:0]   htb;
    logic [HNUM*DATABIT-1:0]   ht1;
    logic [HNUM*DATABIT-1:0]   zt;
    logic [HNUM*DATABIT-1:0]   f3;
    logic                      out_valid;
    logic                      out_ready;
    logic [HNUM*DATABIT-1:0]   result;
    logic                      sat_flag;

    modport master (
        output in_valid, acc_mode, n, xt, htb, ht1, zt, f3, out_ready,
        input  in_ready, out_valid, result, sat_flag
    );

    modport slave (
        input  in_valid, acc_mode, n, xt, htb, ht1, zt, f3, out_ready,
        output in_ready, out_valid, result, sat_flag
    );
endinterface

// File: rtl/gru_dh_dw_update_qmul.sv
// ---------------------------------------------------------------------------
// gru_qmul
// Combinational signed fixed-point multiply: full-width product, arithmetic
// right shift by FRAC (floor), clamp to the DATABIT range.
//   i_a, i_b : signed operands
//   o_p      : saturated product
//   o_ovf    : high when the clamp engaged
// ---------------------------------------------------------------------------
module gru_qmul #(
    parameter int DATABIT = 16,
    parameter int FRAC    = 12
) (
    input  logic signed [DATABIT-1:0] i_a,
    input  logic signed [DATABIT-1:0] i_b,
    output logic signed [DATABIT-1:0] o_p,
    output logic                      o_ovf
);
    logic signed [2*DATABIT-1:0] w_prod;
    logic signed [2*DATABIT-1:0] w_sh;
    logic        [DATABIT:0]     w_top;

    // Sign-extend explicitly so the product is computed at full width.
    assign w_prod = $signed({{DATABIT{i_a[DATABIT-1]}}, i_a}) *
                    $signed({{DATABIT{i_b[DATABIT-1]}}, i_b});
    assign w_sh   = w_prod >>> FRAC;
    // Fits in DATABIT only if every bit from the sign down to DATABIT-1 agrees.
    assign w_top  = w_sh[2*DATABIT-1:DATABIT-1];
    assign o_ovf  = !((&w_top) | ~(|w_top));
    assign o_p    = o_ovf ? (w_sh[2*DATABIT-1] ? {1'b1, {(DATABIT-1){1'b0}}}
                                               : {1'b0, {(DATABIT-1){1'b1}}})
                          : w_sh[DATABIT-1:0];
endmodule

// File: rtl/gru_dh_dw_update.sv
// ---------------------------------------------------------------------------
// gru_dh_dw_update
// Adds the A-term xt*(htb_n-ht1_n)*zt_n*(1-zt_n) of the selected hidden unit
// n onto the upstream f3 vector, optionally accumulating into a per-lane bank
// across timesteps. One shared saturating multiplier, stepped by a small FSM.
//   clk, rst     : clock, asynchronous active-high reset
//   clr          : synchronous clear of the accumulator bank
//   bus (slave)  : request (xt, n, htb, ht1, zt, f3, acc_mode) and
//                  response (result, sat_flag) with valid/ready handshakes
//   o_dbg_state  : current FSM state for observation
// ---------------------------------------------------------------------------
module gru_dh_dw_update #(
    parameter int DATABIT = gru_fx_pkg::DATABIT,
    parameter int FRAC    = gru_fx_pkg::FRAC,
    parameter int HNUM    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    gru_dh_dw_update_if.slave      bus,
    output logic [2:0]             o_dbg_state
);
    localparam int NW = $clog2(HNUM);

    localparam logic [2:0] S_IDLE = gru_fx_pkg::ST_IDLE;
    localparam logic [2:0] S_LOAD = gru_fx_pkg::ST_LOAD;
    localparam logic [2:0] S_M1   = gru_fx_pkg::ST_M1;
    localparam logic [2:0] S_M2   = gru_fx_pkg::ST_M2;
    localparam logic [2:0] S_M3   = gru_fx_pkg::ST_M3;
    localparam logic [2:0] S_ADD  = gru_fx_pkg::ST_ADD;
    localparam logic [2:0] S_DONE = gru_fx_pkg::ST_DONE;

    localparam logic signed [DATABIT-1:0] ONE = {{(DATABIT-1){1'b0}}, 1'b1} << FRAC;

    function automatic logic signed [DATABIT-1:0] sat_w(input logic signed [DATABIT:0] v);
        if (v[DATABIT] != v[DATABIT-1])
            sat_w = v[DATABIT] ? {1'b1, {(DATABIT-1){1'b0}}} : {1'b0, {(DATABIT-1){1'b1}}};
        else
            sat_w = v[DATABIT-1:0];
    endfunction

    function automatic logic clip_w(input logic signed [DATABIT:0] v);
        return v[DATABIT] ^ v[DATABIT-1];
    endfunction

    logic [2:0]                r_state;
    logic                      r_acc_mode;
    logic [NW-1:0]             r_n;
    logic signed [DATABIT-1:0] r_xt, r_htb, r_ht1, r_zt;
    logic signed [DATABIT-1:0] r_d, r_om, r_p1, r_p2, r_a;
    logic [HNUM*DATABIT-1:0]   r_f3;
    logic [HNUM*DATABIT-1:0]   r_acc;
    logic [HNUM*DATABIT-1:0]   r_result;
    logic                      r_out_valid;
    logic                      r_sat;

    logic signed [DATABIT-1:0] w_sel_htb, w_sel_ht1, w_sel_zt;
    logic signed [DATABIT:0]   w_d_wide, w_om_wide;
    logic signed [DATABIT-1:0] w_qa, w_qb, w_q;
    logic                      w_q_ovf;
    logic signed [DATABIT:0]   w_t1 [HNUM];
    logic signed [DATABIT:0]   w_t2 [HNUM];
    logic signed [DATABIT-1:0] w_s1 [HNUM];
    logic signed [DATABIT-1:0] w_ak [HNUM];
    logic signed [DATABIT-1:0] w_fk [HNUM];
    logic signed [DATABIT-1:0] w_bk [HNUM];
    logic [HNUM*DATABIT-1:0]   w_s;
    logic                      w_add_clip;

    // Lane n of the per-unit vectors; an out-of-range n selects zeros, which
    // walks a zero A-term through the multiplier without any clamp.
    always_comb begin
        w_sel_htb = '0;
        w_sel_ht1 = '0;
        w_sel_zt  = '0;
        for (int k = 0; k < HNUM; k++) begin
            if (bus.n == NW'(k)) begin
                w_sel_htb = bus.htb[k*DATABIT +: DATABIT];
                w_sel_ht1 = bus.ht1[k*DATABIT +: DATABIT];
                w_sel_zt  = bus.zt[k*DATABIT +: DATABIT];
            end
        end
    end

    assign w_d_wide  = {r_htb[DATABIT-1], r_htb} - {r_ht1[DATABIT-1], r_ht1};
    assign w_om_wide = {ONE[DATABIT-1], ONE} - {r_zt[DATABIT-1], r_zt};

    // Operand routing for the single shared multiplier.
    always_comb begin
        w_qa = '0;
        w_qb = '0;
        case (r_state)
            S_M1: begin w_qa = r_zt; w_qb = r_om; end
            S_M2: begin w_qa = r_d;  w_qb = r_p1; end
            S_M3: begin w_qa = r_p2; w_qb = r_xt; end
            default: ;
        endcase
    end

    gru_qmul #(.DATABIT(DATABIT), .FRAC(FRAC)) u_qmul (
        .i_a   (w_qa),
        .i_b   (w_qb),
        .o_p   (w_q),
        .o_ovf (w_q_ovf)
    );

    // Lane sums for the ADD step; the A-term lands only on lane r_n.
    always_comb begin
        w_add_clip = 1'b0;
        w_s        = '0;
        for (int k = 0; k < HNUM; k++) begin
            w_fk[k] = r_f3[k*DATABIT +: DATABIT];
            w_bk[k] = r_acc[k*DATABIT +: DATABIT];
            w_ak[k] = (r_n == NW'(k)) ? r_a : '0;
            w_t1[k] = {w_fk[k][DATABIT-1], w_fk[k]} + {w_ak[k][DATABIT-1], w_ak[k]};
            w_s1[k] = sat_w(w_t1[k]);
            w_add_clip = w_add_clip | clip_w(w_t1[k]);
            w_t2[k] = '0;
            if (r_acc_mode) begin
                w_t2[k] = {w_bk[k][DATABIT-1], w_bk[k]} + {w_s1[k][DATABIT-1], w_s1[k]};
                w_add_clip = w_add_clip | clip_w(w_t2[k]);
                w_s[k*DATABIT +: DATABIT] = sat_w(w_t2[k]);
            end else begin
                w_s[k*DATABIT +: DATABIT] = w_s1[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc_mode  <= 1'b0;
            r_n         <= '0;
            r_xt        <= '0;
            r_htb       <= '0;
            r_ht1       <= '0;
            r_zt        <= '0;
            r_d         <= '0;
            r_om        <= '0;
            r_p1        <= '0;
            r_p2        <= '0;
            r_a         <= '0;
            r_f3        <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_xt       <= bus.xt;
                    r_n        <= bus.n;
                    r_acc_mode <= bus.acc_mode;
                    r_htb      <= w_sel_htb;
                    r_ht1      <= w_sel_ht1;
                    r_zt       <= w_sel_zt;
                    r_f3       <= bus.f3;
                    r_sat      <= 1'b0;
                    r_state    <= S_LOAD;
                end
                S_LOAD: begin
                    r_d     <= sat_w(w_d_wide);
                    r_om    <= sat_w(w_om_wide);
                    r_sat   <= r_sat | clip_w(w_d_wide) | clip_w(w_om_wide);
                    r_state <= S_M1;
                end
                S_M1: begin
                    r_p1    <= w_q;
                    r_sat   <= r_sat | w_q_ovf;
                    r_state <= S_M2;
                end
                S_M2: begin
                    r_p2    <= w_q;
                    r_sat   <= r_sat | w_q_ovf;
                    r_state <= S_M3;
                end
                S_M3: begin
                    r_a     <= w_q;
                    r_sat   <= r_sat | w_q_ovf;
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    r_result    <= w_s;
                    r_out_valid <= 1'b1;
                    r_sat       <= r_sat | w_add_clip;
                    r_state     <= S_DONE;
                end
                S_DONE: if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Accumulator bank: clr takes priority over the ADD-step write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_acc <= '0;
        else if (clr)
            r_acc <= '0;
        else if (r_state == S_ADD && r_acc_mode)
            r_acc <= w_s;
    end

    assign bus.in_ready  = (r_state == S_IDLE) && !rst;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.sat_flag  = r_sat;
    assign o_dbg_state   = r_state;
endmodule
